// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
//
// Shares one single-port frame-buffer RAM (1-cycle read latency) between the
// VGA pixel fetch path and a pixel writer (drawing engine).
//
// The display always wins: a display request in cycle N is registered onto the
// RAM port in N+1, and its data is flagged valid in N+2. Writer pixels are
// absorbed into a small FIFO and drained only in cycles where the display
// makes no request, which in practice means blanking. A saturating counter
// measures how long the FIFO head has been blocked by the display. When the
// counter reaches STARVE_LIMIT it sets a sticky flag, which software clears.
//
// Handshake (writer side): valid/ready. The writer holds wr_addr/wr_data
// stable while wr_valid=1. A pixel transfers on any rising edge where
// wr_valid & wr_ready. wr_ready depends only on the registered FIFO level
// and never on wr_valid, so a pop in the same cycle does not raise wr_ready
// early.
//
// Ports
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   disp_req/addr      display read request and address (one pixel per cycle)
//   disp_rdata/rvalid  read data (straight from mem_rdata) and its valid flag
//   wr_valid/addr/data writer pixel, accepted when wr_ready
//   wr_ready           FIFO not full
//   mem_en/we/addr/wdata  registered RAM port controls
//   mem_rdata          RAM read data, valid one cycle after a read enable
//   wbuf_level         FIFO occupancy 0..WBUF_DEPTH
//   wr_starve          sticky starvation flag
//   starve_clr         clears wr_starve (a set in the same cycle wins)
//   dbg_gnt            grant issued last cycle: 0 idle, 1 display, 2 write
// ---------------------------------------------------------------------------
module fb_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 1,
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 800,
  localparam int LVL_W       = $clog2(WBUF_DEPTH) + 1,
  localparam int PTR_W       = $clog2(WBUF_DEPTH),
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  // display read path
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  // writer path
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic [LVL_W-1:0]  wbuf_level,
  output logic              wr_starve,
  input  logic              starve_clr,
  output logic [1:0]        dbg_gnt
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;

  gnt_e              r_gnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rv_s1;
  logic              r_rv_s2;

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_starve;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  gnt_e              w_gnt;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_cnt_at_limit;

  assign w_empty        = (r_level == '0);
  assign w_full         = (r_level == LVL_W'(WBUF_DEPTH));
  assign w_push         = wr_valid & ~w_full;
  assign w_head_addr    = r_fifo_addr[r_rptr];
  assign w_head_data    = r_fifo_data[r_rptr];
  assign w_cnt_at_limit = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Fixed priority: display first, then a queued write, else idle.
  always_comb begin
    w_gnt = GNT_IDLE;
    if (disp_req) begin
      w_gnt = GNT_DISP;
    end else if (!w_empty) begin
      w_gnt = GNT_WR;
    end
  end

  assign w_pop = (w_gnt == GNT_WR);

  // -------------------------------------------------------------------------
  // Write FIFO storage. Data entries need no reset because the level decides
  // what is valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because WBUF_DEPTH is a power of two. A pop
  // always reads the old head, so a push and a pop in the same cycle keep
  // acceptance order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Grant state machine and registered RAM port. On an idle cycle the
  // address and write data hold, so the RAM pins do not toggle during
  // blanking. A display read leaves mem_wdata unchanged.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt       <= GNT_IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rv_s1     <= 1'b0;
      r_rv_s2     <= 1'b0;
    end else begin
      r_gnt <= w_gnt;
      case (w_gnt)
        GNT_DISP: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= disp_addr;
        end
        GNT_WR: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_head_addr;
          r_mem_wdata <= w_head_data;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
      // Stage 1 marks the RAM read cycle. Stage 2 lines up with mem_rdata.
      r_rv_s1 <= (w_gnt == GNT_DISP);
      r_rv_s2 <= r_rv_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Starvation monitor. The counter only runs while a write waits behind the
  // display. Any pop or an empty FIFO resets it, and it saturates at the
  // limit. The flag samples the registered counter, so it rises one cycle
  // after the limit is reached.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      if (w_empty || w_pop) begin
        r_starve_cnt <= '0;
      end else if (disp_req && !w_cnt_at_limit) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      if (w_cnt_at_limit) begin
        r_starve <= 1'b1;
      end else if (starve_clr) begin
        r_starve <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign disp_rdata  = mem_rdata;
  assign disp_rvalid = r_rv_s2;
  assign wr_ready    = ~w_full;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign wbuf_level  = r_level;
  assign wr_starve   = r_starve;
  assign dbg_gnt     = r_gnt;

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter
//
// Directed and random stimulus for fb_arbiter. A behavioural RAM answers the
// DUT's port. Addresses that were never written read back as the parity of
// the address.
//
// The reference model tracks the write FIFO as a queue of {addr,data}. It
// also keeps a two-deep pipe of display requests and an integer starvation
// count, and from these predicts every RAM-port and status output.
//
// Reads always target the lower half of the address space and writes the
// upper half. The expected read data is therefore always the preload
// pattern.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 1;
  localparam int WBUF_DEPTH   = 4;
  localparam int STARVE_LIMIT = 800;
  localparam int LVL_W        = $clog2(WBUF_DEPTH) + 1;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [LVL_W-1:0]  wbuf_level;
  logic              wr_starve;
  logic              starve_clr;
  logic [1:0]        dbg_gnt;

  fb_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WBUF_DEPTH  (WBUF_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .disp_rvalid(disp_rvalid),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .wbuf_level (wbuf_level),
    .wr_starve  (wr_starve),
    .starve_clr (starve_clr),
    .dbg_gnt    (dbg_gnt)
  );

  // -------------------------------------------------------------------------
  // Behavioural RAM: 1-cycle read latency, written cells kept in a sparse map
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] ram_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(^a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram_mem[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= ram_mem.exists(mem_addr) ? ram_mem[mem_addr] : pat(mem_addr);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard / reference model
  // -------------------------------------------------------------------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rv1, m_rv2;
  logic [ADDR_W-1:0] m_ra1, m_ra2;
  int                m_cnt;
  logic              m_starve;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_rv1 = 1'b0; m_rv2 = 1'b0; m_ra1 = '0; m_ra2 = '0;
    m_cnt = 0; m_starve = 1'b0;
  endtask

  // Advance one clock with the inputs as currently driven. The model is
  // updated from the rules, then the DUT is checked 1 time unit after the
  // edge.
  task automatic step();
    int sz;
    bit push;
    sz = exp_q.size();
    check("wr_ready", wr_ready, (sz != WBUF_DEPTH));
    check("wbuf_level", wbuf_level, sz);
    push = wr_valid && (sz != WBUF_DEPTH);

    if (m_cnt == STARVE_LIMIT) m_starve = 1'b1;
    else if (starve_clr)       m_starve = 1'b0;
    if (sz > 0 && disp_req) m_cnt = (m_cnt < STARVE_LIMIT) ? m_cnt + 1 : STARVE_LIMIT;
    else                    m_cnt = 0;

    m_rv2 = m_rv1; m_ra2 = m_ra1;
    m_rv1 = disp_req; m_ra1 = disp_addr;

    if (disp_req) begin
      m_en = 1'b1; m_we = 1'b0; m_addr = disp_addr;
    end else if (sz > 0) begin
      m_en = 1'b1; m_we = 1'b1;
      {m_addr, m_wdata} = exp_q.pop_front();
    end else begin
      m_en = 1'b0; m_we = 1'b0;
    end
    if (push) exp_q.push_back({wr_addr, wr_data});

    @(posedge clk);
    #1;
    check("mem_en", mem_en, m_en);
    check("mem_we", mem_we, m_we);
    check("mem_addr", mem_addr, m_addr);
    if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    check("disp_rvalid", disp_rvalid, m_rv2);
    if (m_rv2) check("disp_rdata", disp_rdata, pat(m_ra2));
    check("wr_starve", wr_starve, m_starve);
    check("dbg_gnt", dbg_gnt, m_en ? (m_we ? 32'd2 : 32'd1) : 32'd0);
  endtask

  task automatic drive_idle();
    disp_req = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    starve_clr = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] wr_region(input int unsigned r);
    return {1'b1, r[ADDR_W-2:0]};
  endfunction

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    // 1: reset values, then a few idle cycles
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rvalid", disp_rvalid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_level", wbuf_level, 0);
    check("rst_starve", wr_starve, 0);
    repeat (3) step();

    // 2: one display line, addresses 0..639, then two cycles to drain
    for (int i = 0; i < 640; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(i);
      step();
    end
    disp_req = 1'b0;
    repeat (2) step();

    // 3: display busy, five writes offered, only four fit
    for (int i = 0; i < 5; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(700 + i);
      wr_valid = 1'b1; wr_addr = wr_region(32'h100 + i); wr_data = DATA_W'(i);
      step();
    end
    check("t3_level_full", wbuf_level, WBUF_DEPTH);
    check("t3_ready_low", wr_ready, 0);

    // 3/4: display drops. The first pop sees a full FIFO and the held
    // writer pixel waits. Next cycle it is pushed while the next head pops.
    disp_req = 1'b0;
    step();
    check("t4_level_after_pop", wbuf_level, WBUF_DEPTH - 1);
    check("t4_ready_after_pop", wr_ready, 1);
    step();
    check("t4_level_push_pop", wbuf_level, WBUF_DEPTH - 1);
    wr_valid = 1'b0;
    repeat (6) step();
    check("t4_drained", wbuf_level, 0);

    // 5: one queued write held off by the display for the full limit
    disp_req = 1'b1; disp_addr = ADDR_W'(5);
    wr_valid = 1'b1; wr_addr = wr_region(32'h222); wr_data = 1'b1;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      disp_addr = ADDR_W'(i);
      step();
    end
    check("t5_not_yet", wr_starve, 0);
    step();
    check("t5_set", wr_starve, 1);
    starve_clr = 1'b1;
    step();
    check("t5_set_wins", wr_starve, 1);
    starve_clr = 1'b0; disp_req = 1'b0;
    step();
    check("t5_sticky", wr_starve, 1);
    starve_clr = 1'b1;
    step();
    check("t5_cleared", wr_starve, 0);
    starve_clr = 1'b0;
    repeat (2) step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      disp_req   = ($urandom_range(0, 9) < 7);
      disp_addr  = ADDR_W'($urandom_range(0, (1 << (ADDR_W - 1)) - 1));
      wr_valid   = ($urandom_range(0, 1) == 1);
      wr_addr    = wr_region($urandom);
      wr_data    = DATA_W'($urandom_range(0, 1));
      starve_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    drive_idle();
    repeat (8) step();
    check("rand_drained", wbuf_level, 0);

    // 6: reset while three writes are queued and reads are in flight
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(40 + i);
      wr_valid = 1'b1; wr_addr = wr_region(32'h333 + i); wr_data = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    check("t6_level_3", wbuf_level, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_mem_en", mem_en, 0);
    check("t6_mem_we", mem_we, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_mem_wdata", mem_wdata, 0);
    check("t6_rvalid", disp_rvalid, 0);
    check("t6_level", wbuf_level, 0);
    check("t6_ready", wr_ready, 1);
    check("t6_starve", wr_starve, 0);
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
